// File: rtl/uart_tx_param.sv
// UART transmitter fed from a normal-mode FIFO.
// The frame format is latched once per frame: baud divisor, 5-8 data bits,
// none/even/odd parity, and 1 or 2 stop bits.
// tx and fifordreq are registered.
// tx changes only on bit boundaries.
module uart_tx_param #(
    parameter int DIV_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic [1:0]       parity,
    input  logic             stop2,
    input  logic             fifordempty,
    input  logic [7:0]       fifodata,
    output logic             fifordreq,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    // Extra WAIT cycles after the first one, until fifodata is valid.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   bcnt_q, bcnt_d;
    logic [1:0]         nb_q, nb_d;
    logic               pen_q, pen_d;
    logic               stop2_q, stop2_d;
    logic               par_q, par_d;
    logic [7:0]         sh_q, sh_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [1:0]         wcnt_q, wcnt_d;
    logic               ssec_q, ssec_d;
    logic               tx_q, tx_d;
    logic               req_q, req_d;
    logic               bit_end;

    assign bit_end   = (bcnt_q == '0);
    assign tx        = tx_q;
    assign fifordreq = req_q;
    assign busy      = (state_q != S_IDLE);

    // Next-state logic.
    // tx_d is set only on bit transitions, so the line stays stable within a bit.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bcnt_d   = bcnt_q;
        nb_d     = nb_q;
        pen_d    = pen_q;
        stop2_d  = stop2_q;
        par_d    = par_q;
        sh_d     = sh_q;
        bitcnt_d = bitcnt_q;
        wcnt_d   = wcnt_q;
        ssec_d   = ssec_q;
        tx_d     = tx_q;
        tx_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifordempty) begin
                    div_d   = baud_div;
                    nb_d    = data_bits;
                    pen_d   = parity[1];
                    stop2_d = stop2;
                    par_d   = parity[0];   // odd parity seeds the running XOR with 1
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                wcnt_d  = WAIT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == 2'd0) begin
                    sh_d    = fifodata;
                    bcnt_d  = div_q;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end else begin
                    wcnt_d = wcnt_q - 2'd1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bcnt_d   = div_q;
                    bitcnt_d = 3'd0;
                    tx_d     = sh_q[0];
                    par_d    = par_q ^ sh_q[0];
                    state_d  = S_DATA;
                end else begin
                    bcnt_d = bcnt_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bcnt_d = div_q;
                    if (bitcnt_q == {1'b0, nb_q} + 3'd4) begin
                        if (pen_q) begin
                            tx_d    = par_q;
                            state_d = S_PAR;
                        end else begin
                            tx_d    = 1'b1;
                            ssec_d  = 1'b0;
                            state_d = S_STOP;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        sh_d     = sh_q >> 1;
                        tx_d     = sh_q[1];
                        par_d    = par_q ^ sh_q[1];
                    end
                end else begin
                    bcnt_d = bcnt_q - DIV_W'(1);
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    bcnt_d  = div_q;
                    tx_d    = 1'b1;
                    ssec_d  = 1'b0;
                    state_d = S_STOP;
                end else begin
                    bcnt_d = bcnt_q - DIV_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !ssec_q) begin
                        ssec_d = 1'b1;
                        bcnt_d = div_q;
                    end else begin
                        tx_done = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q - DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_d = (state_d == S_REQ);
    end

    // State and datapath registers.
    // Async reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            bcnt_q   <= '0;
            nb_q     <= 2'd0;
            pen_q    <= 1'b0;
            stop2_q  <= 1'b0;
            par_q    <= 1'b0;
            sh_q     <= 8'd0;
            bitcnt_q <= 3'd0;
            wcnt_q   <= 2'd0;
            ssec_q   <= 1'b0;
            tx_q     <= 1'b1;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bcnt_q   <= bcnt_d;
            nb_q     <= nb_d;
            pen_q    <= pen_d;
            stop2_q  <= stop2_d;
            par_q    <= par_d;
            sh_q     <= sh_d;
            bitcnt_q <= bitcnt_d;
            wcnt_q   <= wcnt_d;
            ssec_q   <= ssec_d;
            tx_q     <= tx_d;
            req_q    <= req_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param (RD_LAT=2).
// Each run builds a per-cycle expectation of tx, fifordreq, busy and tx_done.
// The expectation comes either from hand-written frame bits (table) or from a
// frame-level model (random).
// A FIFO model drives fifodata only in the valid cycle; other cycles get noise.
module tb_uart_tx_param;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div = '0;
    logic [1:0]  data_bits = '0, parity = '0;
    logic        stop2 = 1'b0, fifordempty = 1'b1;
    logic [7:0]  fifodata = '0;
    logic        fifordreq, tx, busy, tx_done;

    uart_tx_param #(.DIV_W(16), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .data_bits(data_bits),
        .parity(parity), .stop2(stop2), .fifordempty(fifordempty),
        .fifodata(fifodata), .fifordreq(fifordreq), .tx(tx), .busy(busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit exp_tx[$], exp_req[$], exp_busy[$], exp_done[$];
    bit act_tx[$], act_req[$];
    byte unsigned push_q[$], fq[$];
    logic [15:0] cfg_div, chg_div;
    logic [1:0]  cfg_db, cfg_par;
    logic        cfg_s2;
    int          chg_k = -1;
    int          act_busy_n;

    typedef struct {
        logic [15:0] div; logic [1:0] db; logic [1:0] par; logic s2;
        logic [7:0] d; int chg_k; logic [15:0] chg_div;
        logic [11:0] exp_bits; int exp_n;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, expv);
    endtask

    task automatic push_exp(input bit t, input bit r, input bit b, input bit d);
        exp_tx.push_back(t); exp_req.push_back(r);
        exp_busy.push_back(b); exp_done.push_back(d);
    endtask

    // One frame: idle cycle, request, LAT wait cycles, then the bits.
    task automatic add_frame(input logic [11:0] bits, input int nbits, input int div);
        push_exp(1, 0, 0, 0);
        push_exp(1, 1, 1, 0);
        for (int i = 0; i < LAT; i++) push_exp(1, 0, 1, 0);
        for (int b = 0; b < nbits; b++)
            for (int c = 0; c <= div; c++)
                push_exp(bits[b], 0, 1, (b == nbits - 1) && (c == div));
    endtask

    // Frame bits from the format rules:
    // start 0, N data LSB first, optional parity making the ones-count even/odd,
    // then the stop bits.
    task automatic model_bits(input logic [7:0] d, input logic [1:0] db,
                              input logic [1:0] par, input logic s2,
                              output logic [11:0] bits, output int nb);
        int n;
        logic [7:0] m;
        n = int'(db) + 5;
        m = 8'((1 << n) - 1);
        bits = '1;
        bits[0] = 1'b0; nb = 1;
        for (int i = 0; i < n; i++) begin bits[nb] = d[i]; nb++; end
        if (par[1]) begin
            bits[nb] = (($countones(d & m) % 2) == 1) ^ par[0];
            nb++;
        end
        bits[nb] = 1'b1; nb++;
        if (s2) begin bits[nb] = 1'b1; nb++; end
    endtask

    // Walk the expectation cycle by cycle (sampled at negedge), acting as FIFO.
    task automatic run(input string nm, input int abort_k, input bit rel);
        int n, btx, breq, bbusy, bdone, pend_k;
        byte unsigned pend_b;
        n = exp_tx.size();
        btx = 0; breq = 0; bbusy = 0; bdone = 0; pend_k = -1; pend_b = 0;
        act_busy_n = 0;
        act_tx.delete(); act_req.delete();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            act_tx.push_back(tx); act_req.push_back(fifordreq);
            if (busy) act_busy_n++;
            if (tx != exp_tx[k]) btx++;
            if (fifordreq != exp_req[k]) breq++;
            if (busy != exp_busy[k]) bbusy++;
            if (tx_done != exp_done[k]) bdone++;
            if (k == abort_k) begin rst_n = 1'b0; break; end
            if (k == 0) begin
                if (rel) rst_n = 1'b1;
                baud_div = cfg_div; data_bits = cfg_db; parity = cfg_par; stop2 = cfg_s2;
                foreach (push_q[i]) fq.push_back(push_q[i]);
                push_q.delete();
            end
            if (k == chg_k) begin
                baud_div = chg_div; data_bits = 2'($urandom);
                parity = 2'($urandom); stop2 = 1'($urandom);
            end
            if (fifordreq && fq.size() > 0) begin
                pend_b = fq.pop_front(); pend_k = k + LAT;
            end
            fifodata = (k == pend_k) ? pend_b : 8'($urandom);
            fifordempty = (fq.size() == 0);
        end
        chk({nm, "_tx"}, btx, 0);
        chk({nm, "_req"}, breq, 0);
        chk({nm, "_busy"}, bbusy, 0);
        chk({nm, "_done"}, bdone, 0);
        exp_tx.delete(); exp_req.delete(); exp_busy.delete(); exp_done.delete();
        chg_k = -1;
    endtask

    task automatic set_cfg(input logic [15:0] dv, input logic [1:0] db,
                           input logic [1:0] p, input logic s2);
        cfg_div = dv; cfg_db = db; cfg_par = p; cfg_s2 = s2;
    endtask

    initial begin
        logic [11:0] bits;
        int nb, d1, gap, nreq;

        //             div db par s2 byte chg_k chg_div bits  n
        tbl[0] = '{16'd0, 2'd3, 2'b00, 1'b0, 8'hA5, -1, 16'd0, 12'h34A, 10};
        tbl[1] = '{16'd0, 2'd3, 2'b10, 1'b0, 8'h07, -1, 16'd0, 12'h60E, 11};
        tbl[2] = '{16'd1, 2'd3, 2'b11, 1'b1, 8'h07, -1, 16'd0, 12'hC0E, 12};
        tbl[3] = '{16'd0, 2'd0, 2'b10, 1'b0, 8'hFF, -1, 16'd0, 12'h0FE, 8};
        tbl[4] = '{16'd3, 2'd3, 2'b00, 1'b0, 8'h3C, 10, 16'd9, 12'h278, 10};
        tbl[5] = '{16'd9, 2'd3, 2'b00, 1'b0, 8'h01, -1, 16'd0, 12'h202, 10};
        tbl[6] = '{16'd2, 2'd2, 2'b11, 1'b0, 8'hD5, -1, 16'd0, 12'h3AA, 10};

        // Reset state, then idle with an empty FIFO.
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1); chk("rst_busy", int'(busy), 0);
        chk("rst_req", int'(fifordreq), 0); chk("rst_done", int'(tx_done), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tx", int'(tx), 1); chk("idle_busy", int'(busy), 0);

        // Directed table.
        foreach (tbl[i]) begin
            set_cfg(tbl[i].div, tbl[i].db, tbl[i].par, tbl[i].s2);
            push_q.push_back(tbl[i].d);
            chg_k = tbl[i].chg_k; chg_div = tbl[i].chg_div;
            add_frame(tbl[i].exp_bits, tbl[i].exp_n, int'(tbl[i].div));
            push_exp(1, 0, 0, 0);
            run($sformatf("vec%0d", i), -1, 1'b0);
            chk($sformatf("vec%0d_len", i), act_busy_n,
                1 + LAT + tbl[i].exp_n * (int'(tbl[i].div) + 1));
        end

        // Two bytes queued back to back: gap of LAT+2 idle-high clocks.
        set_cfg(16'd0, 2'd3, 2'b00, 1'b0);
        push_q.push_back(8'h81); push_q.push_back(8'h3E);
        model_bits(8'h81, 2'd3, 2'b00, 1'b0, bits, nb); add_frame(bits, nb, 0);
        model_bits(8'h3E, 2'd3, 2'b00, 1'b0, bits, nb); add_frame(bits, nb, 0);
        push_exp(1, 0, 0, 0);
        d1 = 1 + LAT + nb;
        run("b2b", -1, 1'b0);
        gap = 0;
        for (int i = d1 + 1; i < act_tx.size() && act_tx[i]; i++) gap++;
        chk("b2b_gap", gap, 4);
        nreq = 0;
        foreach (act_req[i]) nreq += int'(act_req[i]);
        chk("b2b_nreq", nreq, 2);

        // Reset during data bit 3, then a fresh frame after release.
        set_cfg(16'd0, 2'd3, 2'b00, 1'b0);
        push_q.push_back(8'h00);
        model_bits(8'h00, 2'd3, 2'b00, 1'b0, bits, nb); add_frame(bits, nb, 0);
        run("pre_rst", 6 + LAT, 1'b0);
        #1;
        chk("midrst_tx", int'(tx), 1); chk("midrst_busy", int'(busy), 0);
        chk("midrst_req", int'(fifordreq), 0);
        fifordempty = 1'b1;
        set_cfg(16'd1, 2'd3, 2'b10, 1'b1);
        push_q.push_back(8'h5A);
        model_bits(8'h5A, 2'd3, 2'b10, 1'b1, bits, nb); add_frame(bits, nb, 1);
        push_exp(1, 0, 0, 0);
        run("post_rst", -1, 1'b1);

        // Random formats, with random mid-frame input changes that must be ignored.
        for (int it = 0; it < 25; it++) begin
            logic [7:0] d;
            d = 8'($urandom);
            set_cfg(16'($urandom_range(0, 4)), 2'($urandom), 2'($urandom), 1'($urandom));
            push_q.push_back(d);
            chg_k = $urandom_range(1, 30); chg_div = 16'($urandom_range(0, 15));
            model_bits(d, cfg_db, cfg_par, cfg_s2, bits, nb);
            add_frame(bits, nb, int'(cfg_div));
            push_exp(1, 0, 0, 0);
            run($sformatf("rnd%0d", it), -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
